// File: rtl/split_reg_pkg.sv
// -----------------------------------------------------------------------------
// split_reg_pkg
//   Shared pbus interconnect field layout used by split_reg and its users.
//
//   Request word  (REQ_W bits):  {valid, addr[31:0], wdata[31:0], wstrb[3:0]}
//   Response word (RESP_W bits): {rdata[31:0], ready}
//
//   Multi-port buses pack one word per port, port 0 in the LSBs.
// -----------------------------------------------------------------------------
package split_reg_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // Request field offsets
    localparam int WSTRB_LSB = 0;
    localparam int WDATA_LSB = WSTRB_LSB + STRB_W;
    localparam int ADDR_LSB  = WDATA_LSB + DATA_W;
    localparam int VALID_BIT = ADDR_LSB + ADDR_W;
    localparam int REQ_W     = VALID_BIT + 1;

    // Response field offsets
    localparam int READY_BIT = 0;
    localparam int RDATA_LSB = 1;
    localparam int RESP_W    = RDATA_LSB + DATA_W;

endpackage

// File: rtl/split_reg.sv
// -----------------------------------------------------------------------------
// split_reg
//   Registered 1-to-N pbus splitter. A master request is latched, forwarded to
//   the slave picked by addr[P_SLAVES -: SEL_W], and the slave's read data is
//   registered before being returned to the master. Unmapped slave numbers and
//   slaves that stay silent for TIMEOUT cycles get an error response carrying
//   ERR_DATA.
//
//   Handshake: a request is a word whose valid bit is 1. The master holds it
//   until the cycle it sees ready=1 in the response word, and lowers valid in
//   the cycle after. A slave sees valid=1 with stable fields until it answers
//   with ready=1 (one cycle), or until the splitter gives up on it. The
//   splitter ignores master valid while busy, so a valid seen in IDLE is
//   always a new request.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   m_req    in   master request  {valid, addr, wdata, wstrb}
//   m_resp   out  master response {rdata, ready}
//   s_req    out  per-slave requests, slave 0 in the LSBs
//   s_resp   in   per-slave responses, slave 0 in the LSBs
//   busy     out  transaction in flight (FWD, RESP, ERR)
//   err      out  one-cycle pulse on an unmapped or timed-out access
//   err_cnt  out  saturating count of error responses
// -----------------------------------------------------------------------------
module split_reg
    import split_reg_pkg::*;
#(
    parameter int unsigned       N_SLAVES = 4,
    parameter int unsigned       P_SLAVES = 31,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       busy,
    output logic                       err,
    output logic [7:0]                 err_cnt
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // The wait counter only has to reach TIMEOUT-1: the FSM leaves FWD there.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    wait_q;
    logic [7:0]          err_cnt_q;

    // Master request fields
    logic                m_valid;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [STRB_W-1:0]   m_wstrb;
    logic [SEL_W-1:0]    m_sel;
    logic                sel_mapped;

    assign m_valid    = m_req[VALID_BIT];
    assign m_addr     = m_req[ADDR_LSB  +: ADDR_W];
    assign m_wdata    = m_req[WDATA_LSB +: DATA_W];
    assign m_wstrb    = m_req[WSTRB_LSB +: STRB_W];
    assign m_sel      = m_addr[P_SLAVES -: SEL_W];
    assign sel_mapped = (32'(m_sel) < N_SLAVES);

    // Response of the latched slave only; other slaves' ready is never looked at.
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_resp[i*RESP_W + READY_BIT];
                sel_rdata = s_resp[i*RESP_W + RDATA_LSB +: DATA_W];
            end
        end
    end

    // Timeout fires on the TIMEOUT-th FWD cycle; a ready in that same cycle
    // is checked first in the next-state logic and therefore wins.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == TIMEOUT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m_valid) state_d = sel_mapped ? FWD : ERR;
            end
            FWD: begin
                if (sel_ready)        state_d = RESP;
                else if (timeout_hit) state_d = ERR;
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && m_valid) begin
                sel_q   <= m_sel;
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wstrb_q <= m_wstrb;
                wait_q  <= '0;
            end else if (state_q == FWD) begin
                wait_q <= wait_q + CNT_W'(1);
            end

            if (state_q == FWD && sel_ready) begin
                rdata_q <= sel_rdata;
            end

            if (state_q == ERR && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Slaves all see the latched fields; only the selected one gets valid.
    always_comb begin
        s_req = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            s_req[i*REQ_W + ADDR_LSB  +: ADDR_W] = addr_q;
            s_req[i*REQ_W + WDATA_LSB +: DATA_W] = wdata_q;
            s_req[i*REQ_W + WSTRB_LSB +: STRB_W] = wstrb_q;
            s_req[i*REQ_W + VALID_BIT]           = (state_q == FWD) && (sel_q == SEL_W'(i));
        end
    end

    always_comb begin
        m_resp = '0;
        case (state_q)
            RESP: begin
                m_resp[READY_BIT]              = 1'b1;
                m_resp[RDATA_LSB +: DATA_W]    = rdata_q;
            end
            ERR: begin
                m_resp[READY_BIT]              = 1'b1;
                m_resp[RDATA_LSB +: DATA_W]    = ERR_DATA;
            end
            default: m_resp = '0;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign err     = (state_q == ERR);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_split_reg.sv
// -----------------------------------------------------------------------------
// tb_split_reg
//   Self-checking bench for split_reg (3 slaves so slave number 3 is unmapped,
//   TIMEOUT=8). Each transaction's outcome is predicted from the address and
//   the slave's chosen answer delay, and every cycle of it is checked.
// -----------------------------------------------------------------------------
module tb_split_reg;
    import split_reg_pkg::*;

    localparam int          N     = 3;
    localparam int          T     = 8;
    localparam logic [31:0] ERR_D = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    logic                clk = 1'b0;
    logic                rst;
    logic [REQ_W-1:0]    m_req;
    logic [RESP_W-1:0]   m_resp;
    logic [N*REQ_W-1:0]  s_req;
    logic [N*RESP_W-1:0] s_resp;
    logic                busy;
    logic                err;
    logic [7:0]          err_cnt;

    always #5 clk = ~clk;

    split_reg #(
        .N_SLAVES (N),
        .P_SLAVES (31),
        .TIMEOUT  (T),
        .ERR_DATA (ERR_D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .busy    (busy),
        .err     (err),
        .err_cnt (err_cnt)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          model_err_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] s_valid_vec();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = s_req[i*REQ_W + VALID_BIT];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Selected slave gets the given ready/data; every other slave babbles
    // random ready and data, which the splitter must ignore.
    task automatic set_slaves(input int sel, input logic rdy, input logic [31:0] data);
        for (int i = 0; i < N; i++) begin
            if (i == sel) begin
                s_resp[i*RESP_W + READY_BIT]       = rdy;
                s_resp[i*RESP_W + RDATA_LSB +: 32] = data;
            end else begin
                s_resp[i*RESP_W + READY_BIT]       = 1'($urandom_range(0, 1));
                s_resp[i*RESP_W + RDATA_LSB +: 32] = $urandom;
            end
        end
    endtask

    // One access starting at a negedge in IDLE. k = FWD cycle on which the
    // slave answers (0 = never). Returns at a negedge back in IDLE.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int k, input logic [31:0] rdata);
        int  sel;
        int  fwd_cycles;
        bit  is_err;

        // Reference model: outcome straight from the address and slave delay.
        sel = int'(addr >> 30);
        if (sel >= N) begin
            fwd_cycles = 0;
            is_err     = 1'b1;
        end else if (k >= 1 && k <= T) begin
            fwd_cycles = k;
            is_err     = 1'b0;
        end else begin
            fwd_cycles = T;
            is_err     = 1'b1;
        end
        exp_q.push_back(is_err ? ERR_D : rdata);

        m_req = {1'b1, addr, wdata, wstrb};
        set_slaves(-1, 1'b0, 32'h0);
        @(negedge clk);

        for (int j = 1; j <= fwd_cycles; j++) begin
            check("fwd_busy",    busy, 1);
            check("fwd_err",     err, 0);
            check("fwd_m_ready", m_resp[READY_BIT], 0);
            check("fwd_s_valid", s_valid_vec(), 1 << sel);
            check("fwd_s_req",   s_req[sel*REQ_W +: REQ_W], {1'b1, addr, wdata, wstrb});
            // A new-looking request while busy must not disturb the access.
            m_req = {1'b1, 32'($urandom), 32'($urandom), 4'($urandom)};
            set_slaves(sel, (j == k), (j == k) ? rdata : 32'($urandom));
            @(negedge clk);
        end

        check("rsp_m_ready", m_resp[READY_BIT], 1);
        check("rsp_rdata",   m_resp[RDATA_LSB +: 32], exp_q.pop_front());
        check("rsp_err",     err, is_err);
        check("rsp_busy",    busy, 1);
        check("rsp_s_valid", s_valid_vec(), 0);
        if (is_err && model_err_cnt < 255) model_err_cnt++;
        m_req = {1'b0, 32'($urandom), 32'($urandom), 4'($urandom)};
        set_slaves(-1, 1'b0, 32'h0);
        @(negedge clk);

        check("idle_busy",    busy, 0);
        check("idle_m_ready", m_resp[READY_BIT], 0);
        check("idle_err",     err, 0);
        check("idle_err_cnt", err_cnt, model_err_cnt);
    endtask

    // Reset pulsed during FWD of a slave-1 access that is never answered.
    task automatic reset_mid_fwd();
        m_req = {1'b1, 32'h4000_0020, 32'h0BAD_F00D, 4'h3};
        set_slaves(-1, 1'b0, 32'h0);
        @(negedge clk);                       // t+1
        check("rmf_s_valid_t1", s_valid_vec(), 3'b010);
        m_req[VALID_BIT] = 1'b0;
        set_slaves(1, 1'b0, 32'h0);
        @(negedge clk);                       // t+2
        rst = 1'b1;
        @(negedge clk);                       // t+3
        rst = 1'b0;
        model_err_cnt = 0;
        check("rmf_s_valid_t3", s_valid_vec(), 0);
        check("rmf_err_cnt",    err_cnt, 0);
        for (int j = 0; j < 4; j++) begin
            check("rmf_m_ready", m_resp[READY_BIT], 0);
            check("rmf_busy",    busy, 0);
            set_slaves(1, 1'b1, 32'h1111_2222);
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst   = 1'b1;
        m_req = '0;
        set_slaves(-1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_busy",    busy, 0);
        check("rst_m_resp",  m_resp, 0);
        check("rst_err",     err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_s_valid", s_valid_vec(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Mapped read, slave 2 answers on the third FWD cycle.
        run_txn(32'h8000_0010, 32'h0, 4'h0, 3, 32'h1234_5678);
        // Write to slave 0 answered immediately.
        run_txn(32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 1, 32'h0);
        // Unmapped slave number 3.
        run_txn(32'hC000_0000, 32'h0, 4'h0, 0, 32'h0);
        check("unmapped_cnt", err_cnt, 1);
        // Slave that never answers, then one that answers on the last cycle.
        run_txn(32'h4000_0004, 32'h5555_0000, 4'h1, 0, 32'h0);
        run_txn(32'h8000_0008, 32'h0, 4'h0, T, 32'hCAFE_0008);
        check("timeout_cnt", err_cnt, 2);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) begin
            run_txn(32'hC000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF)), $urandom, 4'($urandom), 0, 32'h0);
        end
        check("sat_cnt", err_cnt, 255);

        // Stray readies: slave 2 selected while slaves 0/1 toggle ready.
        run_txn(32'h8000_0040, 32'h0, 4'h0, 5, 32'h7777_8888);

        reset_mid_fwd();
        run_txn(32'h4000_0020, 32'h0BAD_F00D, 4'h3, 2, 32'h2468_ACE0);

        // Randomized traffic over all slave numbers and answer delays.
        for (int i = 0; i < 150; i++) begin
            run_txn($urandom, $urandom, 4'($urandom), $urandom_range(0, T + 2), $urandom);
            repeat ($urandom_range(0, 2)) begin
                check("gap_busy", busy, 0);
                @(negedge clk);
            end
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/split_reg.md
SPLIT_REG -- requirements
Module: split_reg

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of slave ports, legal range 1..16.
REQ-002 SHALL have parameter P_SLAVES, default 31: address bit position of the slave-select MSB.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for slave ready; 0 disables the timeout.
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: rdata returned on an error response.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; the block uses only one clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port m_req, input, `REQ_W bits: master request {valid, addr, wdata, wstrb}.
REQ-008 SHALL have port m_resp, output, `RESP_W bits: master response {rdata, ready}.
REQ-009 SHALL have port s_req, output, N_SLAVES*`REQ_W bits: slave requests, slave 0 in the LSBs.
REQ-010 SHALL have port s_resp, input, N_SLAVES*`RESP_W bits: slave responses, slave 0 in the LSBs.
REQ-011 SHALL have port busy, output, 1 bit: high while a transaction is in flight.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on an unmapped or timed-out access.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating count of error events.

Function
REQ-014 Slave select SHALL be addr[P_SLAVES -: SEL_W], where SEL_W = max(1, clog2(N_SLAVES)).
REQ-015 The FSM SHALL have states IDLE, FWD, RESP and ERR.
REQ-016 In IDLE with m_valid=1, the block SHALL latch sel/addr/wdata/wstrb; next state FWD if sel<N_SLAVES, else ERR.
REQ-017 In FWD, s_valid[sel] SHALL be held high with the latched fields; all other s_valid SHALL be low.
REQ-018 When s_ready[sel]=1 in FWD, the block SHALL register s_rdata[sel] and go to RESP.
REQ-019 RESP SHALL last exactly one cycle with m_ready=1 and m_rdata equal to the registered data, then return to IDLE.
REQ-020 The master deasserts valid in the cycle after m_ready; a valid seen in IDLE after RESP SHALL be a new request.
REQ-021 Latency SHALL be: accept at t, s_valid from t+1, slave ready at t+k (k>=1), m_ready at t+k+1; minimum 2 cycles.
REQ-022 A wait counter SHALL count FWD cycles; when it equals TIMEOUT (TIMEOUT>0), s_valid SHALL drop and the FSM SHALL go to ERR.
REQ-023 A slave ready arriving in the same cycle as the timeout SHALL win: normal RESP, no error.
REQ-024 ERR SHALL last one cycle: m_ready=1, m_rdata=ERR_DATA, err=1, err_cnt incremented, saturating at 255; then IDLE.
REQ-025 A ready from a non-selected slave SHALL be ignored.
REQ-026 busy SHALL be high in FWD, RESP and ERR.
REQ-027 m_ready SHALL never be asserted in IDLE or FWD.
REQ-028 The block SHALL accept no new request while busy=1.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE and clear all s_valid, m_ready, m_rdata, err, busy, the wait counter and err_cnt.
REQ-030 A reset during FWD SHALL abandon the access: s_valid low from the next cycle and no response issued.

Structure
REQ-031 `REQ_W, `RESP_W and the field offsets (valid/addr/wdata/wstrb, rdata/ready) SHALL come from the shared interconnect.vh include.
REQ-032 State encodings and SEL_W SHALL be module localparams, not shared.
REQ-033 The block SHALL be a single module with no sub-module; the wait counter and err_cnt stay inline.
REQ-034 split_reg SHALL be a drop-in replacement for the existing bus splitter on pbus when registered timing is needed.

Verification
REQ-035 Mapped read: N_SLAVES=4, P_SLAVES=31, addr=32'h8000_0010, slave 2 ready at t+3 with rdata 32'h1234_5678 -> s_valid[2] high t+1..t+3, m_ready=1 with rdata 32'h1234_5678 at t+4.
REQ-036 Write to slave 0: wdata 32'hA5A5_A5A5, wstrb 4'hF, slave 0 ready at t+1 -> s_req[0] fields match the request, m_ready at t+2.
REQ-037 Unmapped access: N_SLAVES=3, addr=32'hC000_0000 -> no s_valid, m_ready with 32'hDEADBEEF at t+1, err pulse, err_cnt=1.
REQ-038 Timeout: TIMEOUT=8, slave never ready -> s_valid high for 8 cycles then low, ERR response, err_cnt increments; ready arriving on the 8th cycle -> normal response, no err.
REQ-039 Saturation and stray ready: 260 unmapped accesses -> err_cnt=255; slave 1 ready while slave 3 is selected -> ignored.
REQ-040 Reset mid-FWD: rst pulsed at t+2 of a slave-1 access -> s_valid[1] low at t+3, no m_ready, err_cnt=0, next request served normally.
